// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Other arithmetic-lab blocks may reuse the state encoding.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: computes x - y - bin.
// Produces the difference bit and the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first, one bit per clock.
// Results are held on diff/bout/ovf until the next operation completes.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_subtractor u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last     = (r_cnt == LAST_CNT);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_res <= w_res_next;
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // On the last bit r_a[0]/r_b[0] are the operand sign bits.
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_bout;
                        r_ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 8.
// Each task drives one scenario and checks its outputs inline.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int n_vec;
    int n_err;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, diff, bout, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: busy=%b done=%b diff=%h bout=%b ovf=%b", busy, done, diff, bout, ovf);
    endtask

    task automatic test_vectors();
        logic [7:0] va [5] = '{8'h5A, 8'h00, 8'h80, 8'h33, 8'h7F};
        logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'h01, 8'h33, 8'hFF};
        logic [7:0] vd [5] = '{8'h1E, 8'hFF, 8'h7F, 8'h00, 8'h80};
        logic       vbo[5] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        logic       vov[5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 5; i++) begin
            int  n;
            bit  got;
            @(negedge clk);
            a = va[i]; b = vb[i]; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n = 0; got = 0;
            while (!got && n < 20) begin
                @(posedge clk);
                #1 n++;
                if (done === 1'b1) got = 1;
            end
            n_vec++;
            if (!got || n != 8) begin
                n_err++;
                $display("FAIL vec%0d_latency: got %0d cycles (seen=%0d), want 8", i, n, got);
            end
            n_vec++;
            if ({diff, bout, ovf} !== {vd[i], vbo[i], vov[i]}) begin
                n_err++;
                $display("FAIL vec%0d_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                         i, diff, bout, ovf, vd[i], vbo[i], vov[i]);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_pulse_width: got done=%b busy=%b, want 0 0", i, done, busy);
            end
            $display("op %h - %h -> diff=%h bout=%b ovf=%b after %0d cycles", va[i], vb[i], diff, bout, ovf, n);
        end
    endtask

    task automatic test_ignore_start();
        int  n;
        bit  held_ok;
        bit  idle_ok;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        held_ok = 1;
        for (n = 1; n <= 8; n++) begin
            if (n == 3) begin start = 1'b1; a = 8'h00; b = 8'h01; end
            if (n == 5) begin a = 8'hFF; b = 8'h80; end
            if (n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (n < 8 && ({diff, bout, ovf} !== {8'h80, 1'b1, 1'b1} || done !== 1'b0)) held_ok = 0;
        end
        n_vec++;
        if (!held_ok) begin
            n_err++;
            $display("FAIL ignore_hold: previous result not held during shift (diff=%h), want 80", diff);
        end
        n_vec++;
        if (done !== 1'b1 || {diff, bout, ovf} !== {8'h1E, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ignore_result: got done=%b diff=%h bout=%b ovf=%b, want done=1 diff=1e bout=0 ovf=0",
                     done, diff, bout, ovf);
        end
        idle_ok = 1;
        repeat (4) begin
            @(posedge clk);
            #1 if (busy !== 1'b0 || done !== 1'b0) idle_ok = 0;
        end
        n_vec++;
        if (!idle_ok) begin
            n_err++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b, want idle after done", busy, done);
        end
        $display("ignore_start: diff=%h bout=%b ovf=%b", diff, bout, ovf);
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  got;
        bit  no_done;
        @(negedge clk);
        a = 8'h00; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, diff, bout, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL midreset_clear: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        reset = 1'b0;
        no_done = 1;
        repeat (10) begin
            @(posedge clk);
            #1 if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
        end
        n_vec++;
        if (!no_done) begin
            n_err++;
            $display("FAIL midreset_no_done: got done=%b busy=%b after abort, want 0 0", done, busy);
        end
        @(negedge clk);
        a = 8'h7F; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1 n++;
            if (done === 1'b1) got = 1;
        end
        n_vec++;
        if (!got || n != 8 || {diff, bout, ovf} !== {8'h80, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL midreset_fresh: got seen=%0d n=%0d diff=%h bout=%b ovf=%b, want n=8 diff=80 bout=1 ovf=1",
                     got, n, diff, bout, ovf);
        end
        $display("reset_mid then 7f - ff -> diff=%h bout=%b ovf=%b", diff, bout, ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed [3] = '{8'hF8, 8'h80, 8'h08};
        logic       eb [3] = '{1'b1,  1'b0,  1'b0};
        logic       eo [3] = '{1'b0,  1'b0,  1'b0};
        int pulses;
        pulses = 0;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c > 0) begin
                bit exp_done;
                exp_done = ((c - 1) % 10 == 8);
                n_vec++;
                if (done !== exp_done) begin
                    n_err++;
                    $display("FAIL b2b_done_c%0d: got done=%b, want %b", c - 1, done, exp_done);
                end
                if (exp_done && done === 1'b1) begin
                    int k;
                    k = (c - 1) / 10;
                    pulses++;
                    n_vec++;
                    if ({diff, bout, ovf} !== {ed[k], eb[k], eo[k]}) begin
                        n_err++;
                        $display("FAIL b2b_result%0d: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                                 k, diff, bout, ovf, ed[k], eb[k], eo[k]);
                    end
                    $display("b2b op%0d -> diff=%h bout=%b ovf=%b", k, diff, bout, ovf);
                end
            end
            if (c < 30) begin
                start = 1'b1;
                a = 8'(c * 17 + 3);
                b = 8'(c * 29 + 11);
            end else begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL b2b_pulse_count: got %0d, want 3", pulses);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
